dbus_axil_bridge: RTL and testbench

- Data-side bus bridge. It sits directly downstream of the CPU core's data port (address, write data, write enable, read enable, size) and converts each access into one AXI4-Lite transaction.
- It generates byte strobes for stores and aligns and sign/zero-extends load data for the MEM stage.
- It holds the pipeline with stall_o until the bus transaction completes.

---
 rtl/dbus_axil_bridge_if.sv | 28 ++
 rtl/dbus_axil_bridge.sv | 107 ++++++++++
 tb/tb_dbus_axil_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_axil_bridge_if.sv
// dbus_axil_bridge_if: AXI4-Lite master bus between the data bridge and its slave
interface dbus_axil_bridge_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] awaddr;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dbus_axil_bridge.sv
// dbus_axil_bridge: core data port to AXI4-Lite bridge with store strobes and load extension
module dbus_axil_bridge #(
  parameter int ADDR_W = 32,
  parameter bit STRICT_ALIG = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic [ADDR_W-1:0] data_addr_i,
  input logic [31:0] data_i,
  input logic data_we_i,
  input logic data_re_i,
  input logic [2:0] data_size_i,
  output logic [31:0] data_o,
  output logic stall_o,
  output logic err_o,
  dbus_axil_bridge_if.master m
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, MIS, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] strb_q, strb_n;
  logic [31:0] wdata_q, wdata_n, sh, ld;
  logic [15:0] half;
  logic [2:0] size_q;
  logic aw_done, w_done, err_q, req, is_b, is_h, mis;
  // Request decode: store lane replication/strobes and alignment check
  always_comb begin
    req = data_we_i | data_re_i;
    is_b = data_size_i[1:0] == 2'b00;
    is_h = data_size_i[1:0] == 2'b01;
    mis = STRICT_ALIG & (is_h ? data_addr_i[0] : !is_b & (|data_addr_i[1:0]));
    wdata_n = is_b ? {4{data_i[7:0]}} : is_h ? {2{data_i[15:0]}} : data_i;
    strb_n = is_b ? 4'b0001 << data_addr_i[1:0] : is_h ? 4'b0011 << {data_addr_i[1], 1'b0} : 4'b1111 << data_addr_i[1:0];
  end
  // Load formatting: shifting by the byte offset also yields the truncated word for relaxed alignment
  always_comb begin
    sh = m.rdata >> {addr_q[1:0], 3'b000};
    half = addr_q[1] ? m.rdata[31:16] : m.rdata[15:0];
    ld = size_q[1:0] == 2'b00 ? {{24{~size_q[2] & sh[7]}}, sh[7:0]} :
         size_q[1:0] == 2'b01 ? {{16{~size_q[2] & half[15]}}, half} : sh;
  end
  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req) state_n = mis ? MIS : data_we_i ? WADDR : RADDR;
      WADDR: if ((aw_done | m.awready) & (w_done | m.wready)) state_n = WRESP;
      WRESP: if (m.bvalid) state_n = DONE;
      RADDR: if (m.arready) state_n = RDATA;
      RDATA: if (m.rvalid) state_n = DONE;
      MIS: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  assign m.awaddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign m.araddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign m.awvalid = (state == WADDR) & ~aw_done;
  assign m.wvalid = (state == WADDR) & ~w_done;
  assign m.wdata = wdata_q;
  assign m.wstrb = strb_q;
  assign m.bready = state == WRESP;
  assign m.arvalid = state == RADDR;
  assign m.rready = state == RDATA;
  assign stall_o = rst & req & (state != DONE);
  assign err_o = (state == DONE) & err_q;
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // Request capture, per-channel write completion, response status and load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      strb_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      err_q <= 1'b0;
      data_o <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q <= data_addr_i;
        strb_q <= strb_n;
        wdata_q <= wdata_n;
        size_q <= data_size_i;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        err_q <= 1'b0;
      end
      if (state == WADDR) begin
        aw_done <= aw_done | m.awready;
        w_done <= w_done | m.wready;
      end
      if (state == WRESP && m.bvalid) err_q <= |m.bresp;
      if (state == RDATA && m.rvalid) begin
        err_q <= |m.rresp;
        data_o <= ld;
      end
      if (state == MIS) begin
        err_q <= 1'b1;
        data_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dbus_axil_bridge.sv
// tb_dbus_axil_bridge: directed checks of the data bus bridge against a transaction-level model
module tb_dbus_axil_bridge;
  localparam int ADDR_W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data_addr = '0, data_wd = '0, data_rd;
  logic we = 1'b0, re = 1'b0;
  logic [2:0] size = 3'b010;
  logic stall, err;
  int vectors = 0, miscompares = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [1:0] bresp_c = 2'b00, rresp_c = 2'b00;
  logic [31:0] rdata_c = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
  logic [3:0] m_strb = '0;
  logic m_err = 1'b0;
  int m_kind = 0;
  logic pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0, pv_ar = 0, pr_ar = 0;
  logic [31:0] last_wdata = '0, last_awaddr = '0;
  logic [3:0] last_wstrb = '0;
  logic done_err = 1'b0;

  always #5 clk = ~clk;

  dbus_axil_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  dbus_axil_bridge #(.ADDR_W(ADDR_W), .STRICT_ALIG(1'b1)) dut (
    .clk(clk), .rst(rst), .data_addr_i(data_addr), .data_i(data_wd),
    .data_we_i(we), .data_re_i(re), .data_size_i(size),
    .data_o(data_rd), .stall_o(stall), .err_o(err), .m(bus)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] load_model(logic [2:0] sz, logic [31:0] a, logic [31:0] rd);
    int lane;
    logic [7:0] b8;
    logic [15:0] h16;
    lane = int'(a % 4);
    b8 = rd[8*lane +: 8];
    h16 = rd[16*(lane/2) +: 16];
    case (sz)
      3'b000: return 32'($signed(b8));
      3'b100: return {24'h0, b8};
      3'b001: return 32'($signed(h16));
      3'b101: return {16'h0, h16};
      default: return rd;
    endcase
  endfunction

  // slave model: ready/response after a configurable number of cycles of the matching valid/ready
  initial begin
    {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
    bus.bresp = '0;
    bus.rresp = '0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
      end else begin
        aw_c = bus.awvalid ? aw_c + 1 : 0;
        w_c = bus.wvalid ? w_c + 1 : 0;
        b_c = bus.bready ? b_c + 1 : 0;
        ar_c = bus.arvalid ? ar_c + 1 : 0;
        r_c = bus.rready ? r_c + 1 : 0;
        bus.awready = bus.awvalid && aw_c > aw_dly;
        bus.wready = bus.wvalid && w_c > w_dly;
        bus.bvalid = bus.bready && b_c > b_dly;
        bus.arready = bus.arvalid && ar_c > ar_dly;
        bus.rvalid = bus.rready && r_c > r_dly;
        bus.bresp = bresp_c;
        bus.rresp = rresp_c;
        bus.rdata = rdata_c;
      end
    end
  end

  // per-cycle comparison of bus payload, channel discipline and core-side results
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (bus.awvalid) begin
        chk("awaddr", bus.awaddr, m_addr);
        last_awaddr = bus.awaddr;
      end
      if (bus.wvalid) begin
        chk("wdata", bus.wdata, m_wdata);
        chk("wstrb", {28'h0, bus.wstrb}, {28'h0, m_strb});
        last_wdata = bus.wdata;
        last_wstrb = bus.wstrb;
      end
      if (bus.arvalid) chk("araddr", bus.araddr, m_addr);
      if (pv_aw && !pr_aw) chk("awvalid held", {31'h0, bus.awvalid}, 32'h1);
      if (pv_w && !pr_w) chk("wvalid held", {31'h0, bus.wvalid}, 32'h1);
      if (pv_ar && !pr_ar) chk("arvalid held", {31'h0, bus.arvalid}, 32'h1);
      if (m_kind != 1) chk("no write valid", {30'h0, bus.awvalid, bus.wvalid}, 32'h0);
      if (m_kind != 2) chk("no read valid", {31'h0, bus.arvalid}, 32'h0);
      if (!stall) begin
        chk("data_o", data_rd, m_data);
        chk("err_o", {31'h0, err}, {31'h0, (we | re) & m_err});
      end
      aw_hs += int'(bus.awvalid & bus.awready);
      w_hs += int'(bus.wvalid & bus.wready);
      b_hs += int'(bus.bvalid & bus.bready);
      ar_hs += int'(bus.arvalid & bus.arready);
      r_hs += int'(bus.rvalid & bus.rready);
      {pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar} =
        {bus.awvalid, bus.awready, bus.wvalid, bus.wready, bus.arvalid, bus.arready};
    end
  end

  task automatic access(input logic w, input logic r, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_stall, input string name);
    int n, lane, n_st;
    logic mis;
    @(negedge clk);
    data_addr = a;
    data_wd = d;
    we = w;
    re = r;
    size = sz;
    n = sz[1:0] == 2'b00 ? 1 : sz[1:0] == 2'b01 ? 2 : 4;
    lane = int'(a % 4);
    mis = (lane % n) != 0;
    m_addr = a & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      m_strb[i] = i >= lane && i < lane + n;
      m_wdata[8*i +: 8] = d[8*(i % n) +: 8];
    end
    m_kind = mis ? 3 : w ? 1 : 2;
    if (mis) m_data = '0;
    else if (!w) m_data = load_model(sz, a, rdata_c);
    m_err = mis || (w ? bresp_c != 2'b00 : rresp_c != 2'b00);
    {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
    n_st = 0;
    #1;
    while (stall && n_st < 100) begin
      n_st++;
      @(negedge clk);
      #1;
    end
    chk({name, " stall cycles"}, n_st, exp_stall);
    chk({name, " err at done"}, {31'h0, err}, {31'h0, m_err});
    done_err = err;
    chk({name, " aw handshakes"}, aw_hs, {31'h0, m_kind == 1});
    chk({name, " w handshakes"}, w_hs, {31'h0, m_kind == 1});
    chk({name, " b handshakes"}, b_hs, {31'h0, m_kind == 1});
    chk({name, " ar handshakes"}, ar_hs, {31'h0, m_kind == 2});
    chk({name, " r handshakes"}, r_hs, {31'h0, m_kind == 2});
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    m_kind = 0;
  endtask

  initial begin
    int k;
    #1 rst = 1'b0;
    #1;
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset valids", {27'h0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'h0);
    chk("reset data_o", data_rd, 32'h0);
    chk("reset err_o", {31'h0, err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    aw_dly = 1; w_dly = 1; b_dly = 0;
    access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 4, "sw");
    chk("sw awaddr", last_awaddr, 32'h100);
    chk("sw wstrb", {28'h0, last_wstrb}, 32'hF);
    chk("sw err", {31'h0, done_err}, 32'h0);
    aw_dly = 0; w_dly = 0;
    access(1, 0, 3'b000, 32'h103, 32'h000000A5, 3, "sb");
    chk("sb wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb wstrb", {28'h0, last_wstrb}, 32'h8);
    access(1, 0, 3'b001, 32'h102, 32'h1234BEEF, 3, "sh");
    chk("sh wdata", last_wdata, 32'hBEEFBEEF);
    chk("sh wstrb", {28'h0, last_wstrb}, 32'hC);
    chk("store keeps data_o", data_rd, 32'h0);

    rdata_c = 32'h80F07F01;
    access(0, 1, 3'b000, 32'h3, 32'h0, 3, "lb");
    chk("lb @3", data_rd, 32'hFFFFFF80);
    access(0, 1, 3'b100, 32'h3, 32'h0, 3, "lbu");
    chk("lbu @3", data_rd, 32'h00000080);
    access(0, 1, 3'b001, 32'h0, 32'h0, 3, "lh");
    chk("lh @0", data_rd, 32'h00007F01);
    access(0, 1, 3'b101, 32'h2, 32'h0, 3, "lhu");
    chk("lhu @2", data_rd, 32'h000080F0);
    ar_dly = 2; r_dly = 1;
    access(0, 1, 3'b010, 32'h0, 32'h0, 6, "lw");
    chk("lw", data_rd, 32'h80F07F01);
    ar_dly = 0; r_dly = 0;
    access(0, 1, 3'b111, 32'h4, 32'h0, 3, "funct3 111");
    chk("funct3 111 as word", data_rd, 32'h80F07F01);
    access(1, 1, 3'b010, 32'h200, 32'h01020304, 3, "we+re");
    chk("we+re wdata", last_wdata, 32'h01020304);

    access(0, 1, 3'b010, 32'h102, 32'h0, 2, "mis lw");
    chk("mis err", {31'h0, done_err}, 32'h1);
    chk("mis data_o", data_rd, 32'h0);

    rdata_c = 32'h12345678;
    rresp_c = 2'b10;
    access(0, 1, 3'b010, 32'h104, 32'h0, 3, "slverr lw");
    chk("slverr err", {31'h0, done_err}, 32'h1);
    chk("slverr data", data_rd, 32'h12345678);
    rresp_c = 2'b00;

    aw_dly = 0; w_dly = 3;
    access(1, 0, 3'b010, 32'h108, 32'hA5A55A5A, 6, "decoupled sw");
    w_dly = 0;
    bresp_c = 2'b11;
    access(1, 0, 3'b001, 32'h10A, 32'h0000CAFE, 3, "decerr sh");
    chk("decerr err", {31'h0, done_err}, 32'h1);
    bresp_c = 2'b00;

    r_dly = 5;
    rdata_c = 32'h55AA55AA;
    @(negedge clk);
    data_addr = 32'h10C; re = 1'b1; size = 3'b010;
    m_kind = 2; m_addr = 32'h10C; m_err = 1'b0;
    m_data = load_model(3'b010, 32'h10C, rdata_c);
    k = 0;
    #1;
    while (!bus.rready && k < 20) begin
      k++;
      @(negedge clk);
      #1;
    end
    chk("reached RDATA", {31'h0, bus.rready}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async rready", {31'h0, bus.rready}, 32'h0);
    chk("async stall", {31'h0, stall}, 32'h0);
    chk("async data_o", data_rd, 32'h0);
    re = 1'b0;
    m_kind = 0;
    m_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    r_dly = 0;
    rdata_c = 32'hCAFEF00D;
    access(0, 1, 3'b010, 32'h10C, 32'h0, 3, "lw after reset");
    chk("lw after reset", data_rd, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
